div_issue_ctrl: RTL
===================

Name: div_issue_ctrl

Overview:
- Sits between the EX stage and the iterative divider. Accepts RV32M DIV/DIVU/REM/REMU requests and resolves divide-by-zero and signed overflow locally.
- Issues all other operations to the divider and holds the pipeline stalled while it runs.
- Selects quotient or remainder and presents a one-cycle writeback to the register file.

Parameters:
- DW, 32, operand/result width.
- AW, 5, destination register address width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge).
- req_i  in  1  EX-stage M-ext request valid.
- funct3_i  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; other codes not handled here.
- rs1_i  in  DW  dividend.
- rs2_i  in  DW  divisor.
- rd_i  in  AW  destination register.
- flush_i  in  1  pipeline flush; kills the in-flight op.
- div_dividend_o  out  DW  operand to divider.
- div_divisor_o  out  DW  operand to divider.
- div_signed_o  out  1  signed operation select to divider.
- div_en_o  out  1  divider start.
- div_quot_i  in  DW  divider quotient.
- div_rem_i  in  DW  divider remainder.
- div_done_i  in  1  divider result valid (level, may stay high >1 cycle).
- stall_o  out  1  hold IF/ID/EX.
- wb_en_o  out  1  writeback strobe, one cycle.
- wb_addr_o  out  AW  writeback register.
- wb_data_o  out  DW  writeback data.

Behaviour:
- Reset: state=IDLE. All outputs 0: div_*_o, div_en_o, stall_o, wb_en_o, wb_addr_o, wb_data_o.
- Accept: req_i && funct3_i[2] while state is IDLE or WB. On accept, latch rs1, rs2, rd, signed=~funct3_i[0], sel_rem=funct3_i[1].
- req_i with funct3_i[2]==0: ignored; no stall, no state change.
- Special cases, resolved at accept, divider never started, next state WB:
  - rs2==0: quotient=all ones, remainder=rs1 (signed and unsigned).
  - Signed, rs1==1<<(DW-1), rs2==all ones: quotient=rs1, remainder=0.
- Normal path states:
  - IDLE/WB --accept--> ISSUE.
  - ISSUE: div_en_o=1 for exactly this cycle; operands and signed held stable from ISSUE until leaving WAIT. Next state WAIT.
  - WAIT: on first cycle div_done_i==1, capture div_quot_i or div_rem_i per sel_rem, then go to WB.
  - WB: wb_en_o=1 for one cycle with latched rd and result. Next IDLE, or ISSUE/WB on a back-to-back accept.
- Normal latency: accept cycle -> ISSUE -> WAIT (N divider cycles) -> WB.
- Special-case latency: wb_en_o in the cycle after accept.
- rd==0: full operation runs; wb_en_o forced 0 in WB.
- stall_o: combinational; 1 when (accept in IDLE) or state in {ISSUE, WAIT, DRAIN}; 0 in WB, so the pipeline advances in the writeback cycle.
- flush_i:
  - In ISSUE or WAIT: go to DRAIN; the captured result is discarded and no writeback occurs.
  - DRAIN waits for div_done_i, then goes to IDLE (divider cannot abort). stall_o remains 1 in DRAIN.
  - Flush in the accept cycle blocks the accept.
  - Flush in WB or IDLE: no effect.
- Back-to-back requests with identical operands are issued normally; the divider may finish in fewer cycles, and the only requirement is waiting for div_done_i.
- Reset low mid-operation: next edge forces IDLE, all outputs 0, and any pending result is lost.
- div_done_i outside WAIT/DRAIN: ignored.

Test Plan:
- DIV rs1=0xFFFFFFF9 (-7), rs2=2, rd=5; divider returns quot=0xFFFFFFFD -> div_en_o one pulse, stall_o high until WB, wb_en_o=1, wb_addr_o=5, wb_data_o=0xFFFFFFFD.
- REMU rs1=100, rs2=0, rd=3 -> div_en_o never asserts; wb_data_o=100 one cycle after accept.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> wb_data_o=0x80000000 with no divider start. REM on the same operands -> wb_data_o=0.
- DIVU 1000/7 issued, flush_i asserted during WAIT -> stall_o held until div_done_i, then IDLE; wb_en_o never asserts.
- Back-to-back: REM 17/5 (rd=1) followed immediately by DIV 17/5 (rd=2) accepted in the WB cycle -> wb_data_o=2 to x1, then 3 to x2; second div_en_o pulse occurs in the cycle after the first WB.
- rst=0 asserted during WAIT -> next edge: stall_o=0, wb_en_o=0, div_en_o=0; a later div_done_i produces no writeback.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// Issue controller for the RV32M iterative divider.
// Resolves divide-by-zero and signed overflow locally and stalls the pipeline while the divider runs.
module div_issue_ctrl #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  input  logic [2:0]    funct3_i,
  input  logic [DW-1:0] rs1_i,
  input  logic [DW-1:0] rs2_i,
  input  logic [AW-1:0] rd_i,
  input  logic          flush_i,
  output logic [DW-1:0] div_dividend_o,
  output logic [DW-1:0] div_divisor_o,
  output logic          div_signed_o,
  output logic          div_en_o,
  input  logic [DW-1:0] div_quot_i,
  input  logic [DW-1:0] div_rem_i,
  input  logic          div_done_i,
  output logic          stall_o,
  output logic          wb_en_o,
  output logic [AW-1:0] wb_addr_o,
  output logic [DW-1:0] wb_data_o
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WB, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] dividend_q, dividend_d;
  logic [DW-1:0] divisor_q, divisor_d;
  logic          signed_q, signed_d;
  logic          sel_rem_q, sel_rem_d;
  logic [AW-1:0] rd_q, rd_d;
  logic          div_en_q, div_en_d;
  logic          wb_en_q, wb_en_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;

  logic          accept;
  logic          is_signed;
  logic          is_rem;
  logic          div_zero;
  logic          overflow;
  logic [DW-1:0] special_res;

  always_comb begin
    accept      = req_i && funct3_i[2] && !flush_i && (state_q == IDLE || state_q == WB);
    is_signed   = ~funct3_i[0];
    is_rem      = funct3_i[1];
    div_zero    = (rs2_i == '0);
    overflow    = is_signed && (rs1_i == {1'b1, {(DW-1){1'b0}}}) && (rs2_i == '1);
    // Divide-by-zero takes precedence; overflow only applies with a non-zero divisor.
    if (div_zero) begin
      special_res = is_rem ? rs1_i : '1;
    end else begin
      special_res = is_rem ? '0 : rs1_i;
    end

    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    signed_d   = signed_q;
    sel_rem_d  = sel_rem_q;
    rd_d       = rd_q;
    div_en_d   = 1'b0;
    wb_en_d    = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;

    case (state_q)
      IDLE, WB: begin
        state_d = IDLE;
        if (accept) begin
          dividend_d = rs1_i;
          divisor_d  = rs2_i;
          signed_d   = is_signed;
          sel_rem_d  = is_rem;
          rd_d       = rd_i;
          if (div_zero || overflow) begin
            state_d   = WB;
            wb_en_d   = (rd_i != '0);
            wb_addr_d = rd_i;
            wb_data_d = special_res;
          end else begin
            state_d  = ISSUE;
            div_en_d = 1'b1;
          end
        end
      end
      ISSUE: state_d = flush_i ? DRAIN : WAIT;
      WAIT: begin
        // A flush that coincides with done has nothing left to drain.
        if (flush_i) begin
          state_d = div_done_i ? IDLE : DRAIN;
        end else if (div_done_i) begin
          state_d   = WB;
          wb_en_d   = (rd_q != '0);
          wb_addr_d = rd_q;
          wb_data_d = sel_rem_q ? div_rem_i : div_quot_i;
        end
      end
      DRAIN: if (div_done_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    stall_o = (accept && state_q == IDLE) || state_q == ISSUE || state_q == WAIT ||
              state_q == DRAIN;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      signed_q   <= 1'b0;
      sel_rem_q  <= 1'b0;
      rd_q       <= '0;
      div_en_q   <= 1'b0;
      wb_en_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      signed_q   <= signed_d;
      sel_rem_q  <= sel_rem_d;
      rd_q       <= rd_d;
      div_en_q   <= div_en_d;
      wb_en_q    <= wb_en_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign div_dividend_o = dividend_q;
  assign div_divisor_o  = divisor_q;
  assign div_signed_o   = signed_q;
  assign div_en_o       = div_en_q;
  assign wb_en_o        = wb_en_q;
  assign wb_addr_o      = wb_addr_q;
  assign wb_data_o      = wb_data_q;

endmodule
